// File: rtl/a_operand_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : a_operand_scheduler
//  Description : Round-robin arbiter that shares the three operand buses of
//                a downstream consumer between three requester channels.
//                Each accepted transfer updates one registered bus, then
//                all channels are held off for `delay` settle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module a_operand_scheduler #(
    parameter int g_w1  = 8,
    parameter int g_w2  = 8,
    parameter int g_w3  = 4,
    parameter int delay = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ch1_valid,
    input  logic [g_w1-1:0]     ch1_data,
    output logic                ch1_ready,
    input  logic                ch2_valid,
    input  logic [g_w2+1:0]     ch2_data,
    output logic                ch2_ready,
    input  logic                ch3_valid,
    input  logic [g_w3*2-1:0]   ch3_data,
    output logic                ch3_ready,
    output logic [g_w1-1:0]     d1,
    output logic [g_w2+1:0]     d2,
    output logic [g_w3*2-1:0]   d3,
    output logic                busy,
    output logic [1:0]          last_sel
);

    // Settle counter only has to hold values 0..delay; keep at least one bit
    // so the delay==0 build still has a legal vector.
    localparam int c_CNT_W = (delay < 1) ? 1 : $clog2(delay + 1);
    localparam logic [c_CNT_W-1:0] c_DELAY     = c_CNT_W'(delay);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic               c_HAS_DELAY = (delay > 0);

    // Round-robin pointer encodings: which channel is checked first.
    localparam logic [1:0] c_PTR_CH1 = 2'd0;
    localparam logic [1:0] c_PTR_CH2 = 2'd1;
    localparam logic [1:0] c_PTR_CH3 = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SETTLE = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_ptr;
    logic [g_w1-1:0]      r_d1;
    logic [g_w2+1:0]      r_d2;
    logic [g_w3*2-1:0]    r_d3;
    logic                 r_busy;
    logic [1:0]           r_last_sel;

    logic [2:0]           w_grant;
    logic [2:0]           w_ready;

    // Pick one valid channel, searching from the channel after the last one served.
    always_comb begin
        w_grant = 3'b000;
        case (r_ptr)
            c_PTR_CH2: begin
                if      (ch2_valid) w_grant = 3'b010;
                else if (ch3_valid) w_grant = 3'b100;
                else if (ch1_valid) w_grant = 3'b001;
            end
            c_PTR_CH3: begin
                if      (ch3_valid) w_grant = 3'b100;
                else if (ch1_valid) w_grant = 3'b001;
                else if (ch2_valid) w_grant = 3'b010;
            end
            default: begin
                if      (ch1_valid) w_grant = 3'b001;
                else if (ch2_valid) w_grant = 3'b010;
                else if (ch3_valid) w_grant = 3'b100;
            end
        endcase
    end

    // Ready is only offered in IDLE and never while reset is held, so a
    // handshake coincident with reset cannot be observed by a requester.
    always_comb begin
        w_ready = 3'b000;
        if (!rst && (r_state == S_IDLE)) begin
            w_ready = w_grant;
        end
    end

    assign ch1_ready = w_ready[0];
    assign ch2_ready = w_ready[1];
    assign ch3_ready = w_ready[2];

    // Scheduler FSM: capture the granted payload, then count out the settle window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ptr      <= c_PTR_CH1;
            r_d1       <= '0;
            r_d2       <= '0;
            r_d3       <= '0;
            r_busy     <= 1'b0;
            r_last_sel <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ready[0]) begin
                        r_d1       <= ch1_data;
                        r_last_sel <= 2'd1;
                        r_ptr      <= c_PTR_CH2;
                    end else if (w_ready[1]) begin
                        r_d2       <= ch2_data;
                        r_last_sel <= 2'd2;
                        r_ptr      <= c_PTR_CH3;
                    end else if (w_ready[2]) begin
                        r_d3       <= ch3_data;
                        r_last_sel <= 2'd3;
                        r_ptr      <= c_PTR_CH1;
                    end
                    // With no settle time the FSM stays in IDLE so transfers
                    // can run back to back.
                    if ((|w_ready) && c_HAS_DELAY) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= c_DELAY;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign d1       = r_d1;
    assign d2       = r_d2;
    assign d3       = r_d3;
    assign busy     = r_busy;
    assign last_sel = r_last_sel;

endmodule
`default_nettype wire

// File: tb/tb_a_operand_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_a_operand_scheduler
//  Description : Directed, table-driven self-checking bench for
//                a_operand_scheduler (delay=5 instance) plus a hand-written
//                back-to-back sequence on a delay=0 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_a_operand_scheduler;

    logic clk;
    logic rst;

    // delay = 5 instance
    logic       v1, v2, v3;
    logic [3:0] a1;
    logic [4:0] a2;
    logic [3:0] a3;
    logic       r1, r2, r3;
    logic [3:0] q1;
    logic [4:0] q2;
    logic [3:0] q3;
    logic       qbusy;
    logic [1:0] qsel;

    // delay = 0 instance
    logic       z_v1, z_v2, z_v3;
    logic [3:0] z_a1;
    logic [4:0] z_a2;
    logic [3:0] z_a3;
    logic       z_r1, z_r2, z_r3;
    logic [3:0] z_q1;
    logic [4:0] z_q2;
    logic [3:0] z_q3;
    logic       z_busy;
    logic [1:0] z_sel;

    int n_checks;
    int n_pass;

    a_operand_scheduler #(.g_w1(4), .g_w2(3), .g_w3(2), .delay(5)) dut (
        .clk(clk), .rst(rst),
        .ch1_valid(v1), .ch1_data(a1), .ch1_ready(r1),
        .ch2_valid(v2), .ch2_data(a2), .ch2_ready(r2),
        .ch3_valid(v3), .ch3_data(a3), .ch3_ready(r3),
        .d1(q1), .d2(q2), .d3(q3), .busy(qbusy), .last_sel(qsel)
    );

    a_operand_scheduler #(.g_w1(4), .g_w2(3), .g_w3(2), .delay(0)) dut0 (
        .clk(clk), .rst(rst),
        .ch1_valid(z_v1), .ch1_data(z_a1), .ch1_ready(z_r1),
        .ch2_valid(z_v2), .ch2_data(z_a2), .ch2_ready(z_r2),
        .ch3_valid(z_v3), .ch3_data(z_a3), .ch3_ready(z_r3),
        .d1(z_q1), .d2(z_q2), .d3(z_q3), .busy(z_busy), .last_sel(z_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = one clock cycle: inputs driven after the falling edge, and the
    // state expected at that moment (ready is combinational from this row's
    // inputs, the rest reflects the previous rising edge).
    typedef struct {
        logic       rst;
        logic [2:0] v;      // {ch3, ch2, ch1}
        logic [3:0] a1;
        logic [4:0] a2;
        logic [3:0] a3;
        logic [2:0] rdy;    // {ch3, ch2, ch1}
        logic       busy;
        logic [3:0] e1;
        logic [4:0] e2;
        logic [3:0] e3;
        logic [1:0] sel;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int n, input logic rs, input logic [2:0] v,
                       input logic [3:0] i1, input logic [4:0] i2, input logic [3:0] i3,
                       input logic [2:0] rdy, input logic b,
                       input logic [3:0] e1, input logic [4:0] e2, input logic [3:0] e3,
                       input logic [1:0] sel);
        vec_t t;
        t.rst = rs; t.v = v; t.a1 = i1; t.a2 = i2; t.a3 = i3;
        t.rdy = rdy; t.busy = b; t.e1 = e1; t.e2 = e2; t.e3 = e3; t.sel = sel;
        for (int k = 0; k < n; k++) vq.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        {v1, v2, v3} = 3'b111;
        a1 = 4'h0; a2 = 5'h00; a3 = 4'h0;
        {z_v1, z_v2, z_v3} = 3'b000;
        z_a1 = 4'h0; z_a2 = 5'h00; z_a3 = 4'h0;

        //  n  rst v       a1    a2     a3    rdy    busy e1    e2     e3    sel
        // Reset held two cycles with every valid high.
        add(2, 1, 3'b111, 4'h0, 5'h00, 4'h0, 3'b000, 0, 4'h0, 5'h00, 4'h0, 2'd0);
        // Single ch2 request, then exactly five busy cycles.
        add(1, 0, 3'b010, 4'h0, 5'h15, 4'h0, 3'b010, 0, 4'h0, 5'h00, 4'h0, 2'd0);
        add(5, 0, 3'b000, 4'h0, 5'h00, 4'h0, 3'b000, 1, 4'h0, 5'h15, 4'h0, 2'd2);
        add(1, 0, 3'b000, 4'h0, 5'h00, 4'h0, 3'b000, 0, 4'h0, 5'h15, 4'h0, 2'd2);
        // Reset back to ch1 priority; a ch1 request during reset is ignored.
        add(1, 1, 3'b001, 4'hF, 5'h00, 4'h0, 3'b000, 0, 4'h0, 5'h15, 4'h0, 2'd2);
        // Contention: all three valid, grants at relative cycles 0, 6, 12.
        add(1, 0, 3'b111, 4'hA, 5'h0B, 4'hC, 3'b001, 0, 4'h0, 5'h00, 4'h0, 2'd0);
        add(5, 0, 3'b111, 4'hA, 5'h0B, 4'hC, 3'b000, 1, 4'hA, 5'h00, 4'h0, 2'd1);
        add(1, 0, 3'b111, 4'hA, 5'h0B, 4'hC, 3'b010, 0, 4'hA, 5'h00, 4'h0, 2'd1);
        add(5, 0, 3'b111, 4'hA, 5'h0B, 4'hC, 3'b000, 1, 4'hA, 5'h0B, 4'h0, 2'd2);
        add(1, 0, 3'b111, 4'hA, 5'h0B, 4'hC, 3'b100, 0, 4'hA, 5'h0B, 4'h0, 2'd2);
        // After ch3: ch1 and ch3 both valid, ch1 wins at relative cycle 18.
        add(5, 0, 3'b101, 4'h5, 5'h0B, 4'hC, 3'b000, 1, 4'hA, 5'h0B, 4'hC, 2'd3);
        add(1, 0, 3'b101, 4'h5, 5'h0B, 4'hC, 3'b001, 0, 4'hA, 5'h0B, 4'hC, 2'd3);
        // Two settle cycles, then reset on the third with ch3 waiting.
        add(2, 0, 3'b000, 4'h0, 5'h00, 4'h0, 3'b000, 1, 4'h5, 5'h0B, 4'hC, 2'd1);
        add(1, 1, 3'b100, 4'h0, 5'h00, 4'h9, 3'b000, 1, 4'h5, 5'h0B, 4'hC, 2'd1);
        // Buses cleared, ch3 served immediately after reset drops.
        add(1, 0, 3'b100, 4'h0, 5'h00, 4'h9, 3'b100, 0, 4'h0, 5'h00, 4'h0, 2'd0);
        add(1, 0, 3'b000, 4'h0, 5'h00, 4'h0, 3'b000, 1, 4'h0, 5'h00, 4'h9, 2'd3);

        @(negedge clk);
        foreach (vq[i]) begin
            rst = vq[i].rst;
            {v3, v2, v1} = vq[i].v;
            a1 = vq[i].a1; a2 = vq[i].a2; a3 = vq[i].a3;
            #1;
            chk($sformatf("row%0d ready", i), 32'({r3, r2, r1}), 32'(vq[i].rdy));
            chk($sformatf("row%0d busy", i), 32'(qbusy), 32'(vq[i].busy));
            chk($sformatf("row%0d buses", i), 32'({q1, q2, q3}),
                32'({vq[i].e1, vq[i].e2, vq[i].e3}));
            chk($sformatf("row%0d last_sel", i), 32'(qsel), 32'(vq[i].sel));
            @(negedge clk);
        end
        rst = 1'b0;
        {v1, v2, v3} = 3'b000;

        // delay = 0: ch1 streams 1,2,3,4 back to back; d1 trails by one cycle.
        for (int k = 1; k <= 5; k++) begin
            z_v1 = (k <= 4);
            z_a1 = (k <= 4) ? 4'(k) : 4'h0;
            #1;
            chk($sformatf("d0 step%0d ready", k), 32'({z_r3, z_r2, z_r1}),
                (k <= 4) ? 32'h1 : 32'h0);
            chk($sformatf("d0 step%0d busy", k), 32'(z_busy), 32'h0);
            chk($sformatf("d0 step%0d d1", k), 32'(z_q1), 32'(k - 1));
            chk($sformatf("d0 step%0d sel", k), 32'(z_sel), (k == 1) ? 32'h0 : 32'h1);
            @(negedge clk);
        end
        chk("d0 other buses", 32'({z_q2, z_q3}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
